// File: rtl/dm_axi_master.sv
// ---------------------------------------------------------------------------
// dm_axi_master
//
// Bridges the CPU data-memory port to one AXI4 master. Every access is a
// single beat (LEN=0, SIZE=4 bytes, INCR). The CPU is frozen through
// DM_STALL for as long as the bus transaction is in flight. One DONE
// cycle with DM_STALL low then lets the pipeline step past the access.
//
// Optional feature macro: DM_AXI_RESP_CHK_EN
//   defined   : a non-OKAY RRESP/BRESP sets the sticky resp_err flag, and
//               an errored read loads rdata with zero.
//   undefined : responses are ignored, resp_err stays 0, and rdata always
//               takes RDATA.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   MemRead            load request from the MEM stage
//   MemWrite[3:0]      active-low byte write enables (4'hf = no write)
//   addr, wdata        byte address and lane-aligned store data
//   rdata              registered load data
//   DM_STALL           pipeline freeze
//   AR*/R*/AW*/W*/B*   AXI4 master channels (single beat)
//   resp_err           sticky bus-error flag
// ---------------------------------------------------------------------------
module dm_axi_master #(
  parameter int unsigned          ID_WIDTH  = 4,
  parameter logic [ID_WIDTH-1:0]  MASTER_ID = 4'h1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MemRead,
  input  logic [3:0]          MemWrite,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                DM_STALL,
  output logic [ID_WIDTH-1:0] ARID,
  output logic [31:0]         ARADDR,
  output logic [3:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [ID_WIDTH-1:0] RID,
  input  logic [31:0]         RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY,
  output logic [ID_WIDTH-1:0] AWID,
  output logic [31:0]         AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [31:0]         WDATA,
  output logic [3:0]          WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [ID_WIDTH-1:0] BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic                resp_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        resp_err_q, resp_err_d;

  logic        wr_s;
  logic        req_s;
  logic        busy_s;
  logic        aw_done_s;
  logic        w_done_s;
  logic        unused_s;

  assign wr_s  = (MemWrite != 4'hf);
  assign req_s = MemRead | wr_s;

  // In AW the valid flops double as the per-channel "not yet done" flags:
  // a channel is done once its valid has dropped or is handshaking now.
  assign aw_done_s = ~awvalid_q | AWREADY;
  assign w_done_s  = ~wvalid_q  | WREADY;

  assign busy_s = (state_q == S_AR) | (state_q == S_R) |
                  (state_q == S_AW) | (state_q == S_B);

  // The stall must rise in the same cycle as the request, so it is decoded
  // combinationally; reset forces it low so a frozen pipeline can restart.
  assign DM_STALL = ~rst & (((state_q == S_IDLE) & req_s) | busy_s);

  assign ARID    = MASTER_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = 4'h0;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;
  assign AWID    = MASTER_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = 4'h0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign AWVALID = awvalid_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WLAST   = wvalid_q;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;
  assign rdata   = rdata_q;
  assign resp_err = resp_err_q;

`ifdef DM_AXI_RESP_CHK_EN
  assign unused_s = ^{RID, BID, RLAST, addr[1:0]};
`else
  assign unused_s = ^{RID, BID, RLAST, addr[1:0], RRESP, BRESP};
`endif

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    resp_err_d = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          addr_d  = {addr[31:2], 2'b00};
          wdata_d = wdata;
          wstrb_d = ~MemWrite;
          // A store wins when the CPU presents both a load and a store.
          if (wr_s) begin
            state_d   = S_AW;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_AR;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_AR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end else begin
          state_d = S_AR;
        end
      end

      S_R: begin
        if (RVALID) begin
          rready_d = 1'b0;
          state_d  = S_DONE;
`ifdef DM_AXI_RESP_CHK_EN
          if (RRESP != 2'b00) begin
            rdata_d    = 32'h0000_0000;
            resp_err_d = 1'b1;
          end else begin
            rdata_d = RDATA;
          end
`else
          rdata_d = RDATA;
`endif
        end else begin
          state_d = S_R;
        end
      end

      S_AW: begin
        // Address and data channels retire independently of each other.
        if (awvalid_q & AWREADY) begin
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (wvalid_q & WREADY) begin
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        if (aw_done_s & w_done_s) begin
          bready_d = 1'b1;
          state_d  = S_B;
        end else begin
          state_d = S_AW;
        end
      end

      S_B: begin
        if (BVALID) begin
          bready_d = 1'b0;
          state_d  = S_DONE;
`ifdef DM_AXI_RESP_CHK_EN
          if (BRESP != 2'b00) begin
            resp_err_d = 1'b1;
          end else begin
            resp_err_d = resp_err_q;
          end
`endif
        end else begin
          state_d = S_B;
        end
      end

      S_DONE: begin
        // The CPU advances during this cycle; its request is not sampled.
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  // State, latched request and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      wstrb_q    <= 4'h0;
      rdata_q    <= 32'h0000_0000;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule
